// File: rtl/d_latch_pkg.sv
// ---------------------------------------------------------------------------
// d_latch_pkg
// Shared constants for the d_latch_ah transparent latch and its per-bit cell.
//   LATCH_W_DEFAULT       default number of latched bits
//   LATCH_RST_BIT_DEFAULT value each bit is cleared to while reset is low
//   latchResetValue()     builds a full-width reset vector from the bit value
// ---------------------------------------------------------------------------
package d_latch_pkg;

  localparam int   LATCH_W_DEFAULT       = 1;
  localparam logic LATCH_RST_BIT_DEFAULT = 1'b0;

  // Replicates the default clear bit across a vector of up to 64 bits, so the
  // top level can derive its RESET_VALUE default from a single constant.
  function automatic logic [63:0] latchResetValue(input int width);
    logic [63:0] value;
    value = '0;
    for (int i = 0; i < 64; i++) begin
      if (i < width) begin
        value[i] = LATCH_RST_BIT_DEFAULT;
      end
    end
    return value;
  endfunction

endpackage

// File: rtl/d_latch_cell.sv
// ---------------------------------------------------------------------------
// d_latch_cell
// One bit of an active-high transparent D latch with asynchronous,
// active-low clear and complementary outputs.
//   en     in   enable; transparent while high, holds while low
//   reset  in   asynchronous active-low clear, dominates en
//   d      in   data bit
//   q      out  latched bit
//   qb     out  complement of q
// Parameter RESET_BIT is the value q is forced to while reset is low.
// ---------------------------------------------------------------------------
module d_latch_cell
  import d_latch_pkg::*;
#(
  parameter logic RESET_BIT = LATCH_RST_BIT_DEFAULT
) (
  input  logic en,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic qb
);

  logic stateQ;

  // Level-sensitive storage: the clear branch comes first so reset wins over
  // the enable, and there is deliberately no else branch when en is low so
  // that the stored value is held. No initial value is given, so the bit
  // powers up unknown until reset or an enable pulse defines it.
  always_latch begin
    if (!reset) begin
      stateQ <= RESET_BIT;
    end else if (en) begin
      stateQ <= d;
    end
  end

  // Both outputs come from the same storage node, so qb can never equal q.
  assign q  = stateQ;
  assign qb = ~stateQ;

endmodule

// File: rtl/d_latch_ah.sv
// ---------------------------------------------------------------------------
// d_latch_ah
// WIDTH-bit active-high transparent D latch with asynchronous active-low clear
// and complementary outputs. Every bit is an independent latch cell; all bits
// share one enable and one clear.
//   en     in   [1]        enable; transparent while high, holds while low
//   reset  in   [1]        asynchronous active-low clear, dominates en
//   d      in   [WIDTH]    data input
//   q      out  [WIDTH]    latched data
//   qb     out  [WIDTH]    bitwise complement of q
// Parameters: WIDTH (bits), RESET_VALUE (q while reset is low).
// ---------------------------------------------------------------------------
module d_latch_ah
  import d_latch_pkg::*;
#(
  parameter int               WIDTH       = LATCH_W_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VALUE = latchResetValue(WIDTH)
) (
  input  logic             en,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb
);

  // One cell per bit, each seeded with its own bit of the reset vector.
  for (genvar i = 0; i < WIDTH; i++) begin : gCell
    d_latch_cell #(
      .RESET_BIT(RESET_VALUE[i])
    ) uCell (
      .en   (en),
      .reset(reset),
      .d    (d[i]),
      .q    (q[i]),
      .qb   (qb[i])
    );
  end

endmodule

// File: tb/tb_d_latch_ah.sv
`timescale 1ns/100ps
// ---------------------------------------------------------------------------
// tb_d_latch_ah
// Exercises a 1-bit latch along a fixed timeline and an 8-bit latch with
// RESET_VALUE 8'hA5 through a vector table and a randomized walk.
// ---------------------------------------------------------------------------
module tb_d_latch_ah;

  localparam logic [7:0] RV8 = 8'hA5;

  logic       en1, reset1, d1, q1, qb1;
  logic       en8, reset8;
  logic [7:0] d8, q8, qb8;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    logic       reset;
    logic       en;
    logic [7:0] d;
    logic [7:0] expQ;
  } vecT;

  vecT        vecs[10];
  logic [7:0] modelQ;

  d_latch_ah uDut1 (
    .en   (en1),
    .reset(reset1),
    .d    (d1),
    .q    (q1),
    .qb   (qb1)
  );

  d_latch_ah #(
    .WIDTH      (8),
    .RESET_VALUE(RV8)
  ) uDut8 (
    .en   (en8),
    .reset(reset8),
    .d    (d8),
    .q    (q8),
    .qb   (qb8)
  );

  // Enable for the 1-bit latch: toggles every 7 ns from low at t=0, stopping
  // low after the t=28 falling edge.
  initial begin
    en1 = 1'b0;
    repeat (4) #7 en1 = ~en1;
  end

  // Compares q against the expected value and qb against its complement.
  task automatic checkOutput(input string name, input logic [7:0] gotQ,
                             input logic [7:0] gotQb, input logic [7:0] expQ,
                             input logic [7:0] mask);
    checkCount++;
    if ((gotQ & mask) !== (expQ & mask)) begin
      errorCount++;
      $display("[TB] FAIL %s q got %h expected %h at %0t", name, gotQ & mask, expQ & mask, $time);
    end
    checkCount++;
    if ((gotQb & mask) !== (~expQ & mask)) begin
      errorCount++;
      $display("[TB] FAIL %s qb got %h expected %h at %0t", name, gotQb & mask, ~expQ & mask, $time);
    end
  endtask

  // Drives the 8-bit latch inputs and lets them settle.
  task automatic applyStimulus(input logic r, input logic e, input logic [7:0] dv);
    reset8 = r;
    en8    = e;
    d8     = dv;
    #1;
  endtask

  // Behavioural reference: what the 8-bit latch must hold after one input change.
  function automatic logic [7:0] refLatch(input logic [7:0] held, input logic r,
                                          input logic e, input logic [7:0] dv);
    if (r == 1'b0) return RV8;
    if (e == 1'b1) return dv;
    return held;
  endfunction

  // Main sequence: 1-bit timeline, then 8-bit table, then randomized walk.
  initial begin
    logic [7:0] m1;
    m1     = 8'h01;
    reset1 = 1'b1;
    d1     = 1'b0;
    reset8 = 1'b1;
    en8    = 1'b0;
    d8     = 8'h00;

    vecs[0] = '{1'b0, 1'b0, 8'h00, RV8};
    vecs[1] = '{1'b0, 1'b1, 8'hFF, RV8};
    vecs[2] = '{1'b1, 1'b0, 8'hFF, RV8};
    vecs[3] = '{1'b1, 1'b1, 8'h3C, 8'h3C};
    vecs[4] = '{1'b1, 1'b0, 8'h3C, 8'h3C};
    vecs[5] = '{1'b1, 1'b0, 8'hFF, 8'h3C};
    vecs[6] = '{1'b1, 1'b1, 8'hFF, 8'hFF};
    vecs[7] = '{1'b1, 1'b1, 8'h00, 8'h00};
    vecs[8] = '{1'b0, 1'b1, 8'h00, RV8};
    vecs[9] = '{1'b1, 1'b1, 8'h00, 8'h00};

    #3  reset1 = 1'b0;
    #1  checkOutput("w1_reset_no_edge", {7'b0, q1}, {7'b0, qb1}, 8'h00, m1);
    #1  d1 = 1'b1;
    #1  checkOutput("w1_reset_d1", {7'b0, q1}, {7'b0, qb1}, 8'h00, m1);
    #2  checkOutput("w1_reset_over_en", {7'b0, q1}, {7'b0, qb1}, 8'h00, m1);
    #2  d1 = 1'b0;
    #1  checkOutput("w1_reset_over_en_d0", {7'b0, q1}, {7'b0, qb1}, 8'h00, m1);
    #4  d1 = 1'b1;
    #1  checkOutput("w1_reset_en_low", {7'b0, q1}, {7'b0, qb1}, 8'h00, m1);
    #2  reset1 = 1'b1;
    #1  checkOutput("w1_release_hold", {7'b0, q1}, {7'b0, qb1}, 8'h00, m1);
    #1  checkOutput("w1_release_hold2", {7'b0, q1}, {7'b0, qb1}, 8'h00, m1);
    #1.5 checkOutput("w1_en_rise", {7'b0, q1}, {7'b0, qb1}, 8'h01, m1);
    #3.5 d1 = 1'b0;
    #1  checkOutput("w1_transparent", {7'b0, q1}, {7'b0, qb1}, 8'h00, m1);
    #3  d1 = 1'b1;
    #0.5 checkOutput("w1_hold_d1", {7'b0, q1}, {7'b0, qb1}, 8'h00, m1);
    #0.5 d1 = 1'b0;
    #0.5 checkOutput("w1_hold_d0", {7'b0, q1}, {7'b0, qb1}, 8'h00, m1);
    #2.5;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].reset, vecs[i].en, vecs[i].d);
      checkOutput($sformatf("w8_vec%0d", i), q8, qb8, vecs[i].expQ, 8'hFF);
    end

    // Random walk: one input changes per step so d never moves on an en edge.
    modelQ = vecs[9].expQ;
    for (int i = 0; i < 300; i++) begin
      logic       r, e;
      logic [7:0] dv;
      r  = reset8;
      e  = en8;
      dv = d8;
      case ($urandom_range(0, 3))
        0:       r  = ~r;
        1:       e  = ~e;
        default: dv = 8'($urandom);
      endcase
      applyStimulus(r, e, dv);
      modelQ = refLatch(modelQ, r, e, dv);
      checkOutput($sformatf("w8_rand%0d", i), q8, qb8, modelQ, 8'hFF);
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
